// File: rtl/jump_redirect_unit_pkg.sv
// Shared definitions for the jump redirect unit: opcode encodings and default widths.
package jump_redirect_unit_pkg;

    localparam int PC_W_DEF = 8;
    localparam int OP_W     = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NONE = 3'd0,
        OP_JMP  = 3'd1,
        OP_BEQ  = 3'd2,
        OP_BNE  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5
    } op_e;

endpackage

// File: rtl/jump_redirect_unit_ras_stack.sv
// Circular return-address stack: push/pop on posedge, overwrite-oldest on overflow.
// Sticky ovf/unf flags clear only on reset; top is the most recent entry (combinational).
module jump_redirect_unit_ras_stack
    import jump_redirect_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int RAS_DEPTH = 4,
    localparam int SP_W     = $clog2(RAS_DEPTH),
    localparam int DEP_W    = SP_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [PC_W-1:0]  push_dat,
    output logic [PC_W-1:0]  top,
    output logic [DEP_W-1:0] depth,
    output logic             ovf,
    output logic             unf
);

    logic [PC_W-1:0]  r_entry [RAS_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [DEP_W-1:0] r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic [SP_W-1:0]  w_sp_m1;
    logic             w_full;
    logic             w_empty;

    assign w_sp_m1 = r_sp - SP_W'(1);
    assign w_full  = (r_depth == DEP_W'(RAS_DEPTH));
    assign w_empty = (r_depth == '0);

    // sp wraps naturally because RAS_DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (push) begin
            r_entry[r_sp] <= push_dat;
            r_sp          <= r_sp + SP_W'(1);
            if (w_full) begin
                r_ovf <= 1'b1;
            end else begin
                r_depth <= r_depth + DEP_W'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_sp    <= w_sp_m1;
                r_depth <= r_depth - DEP_W'(1);
            end
        end
    end

    assign top   = r_entry[w_sp_m1];
    assign depth = r_depth;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: rtl/jump_redirect_unit.sv
// Fetch-redirect producer: combinational jflag/new_jadd for JMP/BEQ/BNE/CALL/RET plus a RAS.
// Optional saturating redirect counter enabled by the REDIRECT_CNT_EN macro.
module jump_redirect_unit
    import jump_redirect_unit_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RST_VEC   = '0,
    localparam int             DEP_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [PC_W-1:0]  pc,
    input  logic [OP_W-1:0]  op,
    input  logic [PC_W-1:0]  offset,
    input  logic             cmp_eq,
    output logic             jflag,
    output logic [PC_W-1:0]  new_jadd,
    output logic [DEP_W-1:0] ras_depth,
    output logic             ras_ovf,
    output logic             ras_unf
`ifdef REDIRECT_CNT_EN
    ,
    output logic [15:0]      redirect_cnt
`endif
);

    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_ret;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_sel;
    logic            w_take;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;

    // Same-width add is the sign-extended add truncated to PC_W
    assign w_tgt   = pc + offset;
    assign w_ret   = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_push  = instr_valid && (op == OP_CALL);
    assign w_pop   = instr_valid && (op == OP_RET);
    assign w_empty = (ras_depth == '0);

    always_comb begin
        w_take = 1'b0;
        w_sel  = w_tgt;
        if (instr_valid) begin
            case (op)
                OP_JMP, OP_CALL: w_take = 1'b1;
                OP_BEQ:          w_take = cmp_eq;
                OP_BNE:          w_take = ~cmp_eq;
                OP_RET: begin
                    w_take = 1'b1;
                    w_sel  = w_empty ? RST_VEC : w_top;
                end
                default:         w_take = 1'b0;
            endcase
        end
    end

    assign jflag    = reset & w_take;
    assign new_jadd = jflag ? w_sel : '0;

    jump_redirect_unit_ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .push_dat (w_ret),
        .top      (w_top),
        .depth    (ras_depth),
        .ovf      (ras_ovf),
        .unf      (ras_unf)
    );

`ifdef REDIRECT_CNT_EN
    logic [15:0] r_redirect_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_cnt <= '0;
        end else if (jflag && (r_redirect_cnt != 16'hFFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Bench for jump_redirect_unit: vector table for single-cycle decisions, hand sequences for RAS and reset.
module tb_jump_redirect_unit;
    import jump_redirect_unit_pkg::*;

    localparam logic [7:0] RST_VEC = 8'h00;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [7:0] pc;
    logic [2:0] op;
    logic [7:0] offset;
    logic       cmp_eq;
    logic       jflag;
    logic [7:0] new_jadd;
    logic [2:0] ras_depth;
    logic       ras_ovf;
    logic       ras_unf;
`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    jump_redirect_unit #(
        .PC_W      (8),
        .RAS_DEPTH (4),
        .RST_VEC   (RST_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .pc          (pc),
        .op          (op),
        .offset      (offset),
        .cmp_eq      (cmp_eq),
        .jflag       (jflag),
        .new_jadd    (new_jadd),
        .ras_depth   (ras_depth),
        .ras_ovf     (ras_ovf),
`ifdef REDIRECT_CNT_EN
        .redirect_cnt(redirect_cnt),
`endif
        .ras_unf     (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] pc;
        logic [2:0] op;
        logic [7:0] off;
        logic       eq;
        logic       ej;
        logic [7:0] ea;
    } vec_t;

    typedef struct {
        logic       j;
        logic [7:0] a;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[13];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic sb_compare(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_jflag"}, 32'(jflag), 32'(e.j));
            chk({nm, "_jadd"}, 32'(new_jadd), 32'(e.a));
        end
    endtask

    // Drive on negedge, compare combinational outputs, let the op commit on the next posedge
    task automatic step(input string nm, input logic v, input logic [7:0] p, input logic [2:0] o,
                        input logic [7:0] off, input logic eq, input logic ej, input logic [7:0] ea);
        exp_t e;
        @(negedge clk);
        instr_valid = v;
        pc          = p;
        op          = o;
        offset      = off;
        cmp_eq      = eq;
        e.j = ej;
        e.a = ea;
        sb.push_back(e);
        #2;
        sb_compare(nm);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op          = OP_NONE;
    endtask

    initial begin
        exp_t e;

        tbl[0]  = '{1'b1, 8'h10, OP_JMP,  8'hFC, 1'b0, 1'b1, 8'h0C};
        tbl[1]  = '{1'b1, 8'hFE, OP_JMP,  8'h05, 1'b0, 1'b1, 8'h03};
        tbl[2]  = '{1'b1, 8'h20, OP_BEQ,  8'h04, 1'b1, 1'b1, 8'h24};
        tbl[3]  = '{1'b1, 8'h20, OP_BEQ,  8'h04, 1'b0, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 8'h20, OP_BNE,  8'h04, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 8'h20, OP_BNE,  8'h04, 1'b0, 1'b1, 8'h24};
        tbl[6]  = '{1'b1, 8'h33, OP_NONE, 8'h04, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 8'h33, 3'd6,    8'h04, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 8'h33, 3'd7,    8'h04, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 8'h40, OP_JMP,  8'h04, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 8'h40, OP_CALL, 8'h04, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 8'h00, OP_BEQ,  8'hFF, 1'b1, 1'b1, 8'hFF};
        tbl[12] = '{1'b1, 8'h80, OP_JMP,  8'h7F, 1'b0, 1'b1, 8'hFF};

        // Reset state with a JMP presented: redirect must be suppressed
        reset       = 1'b0;
        instr_valid = 1'b1;
        pc          = 8'h10;
        op          = OP_JMP;
        offset      = 8'h04;
        cmp_eq      = 1'b0;
        e.j = 1'b0;
        e.a = 8'h00;
        sb.push_back(e);
        #3;
        sb_compare("rst");
        chk("rst_depth", 32'(ras_depth), 0);
        chk("rst_ovf", 32'(ras_ovf), 0);
        chk("rst_unf", 32'(ras_unf), 0);
        instr_valid = 1'b0;
        op          = OP_NONE;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].op, tbl[i].off,
                 tbl[i].eq, tbl[i].ej, tbl[i].ea);
        end
        chk("tbl_depth", 32'(ras_depth), 0);
        chk("tbl_ovf", 32'(ras_ovf), 0);
        chk("tbl_unf", 32'(ras_unf), 0);

        // CALL then RET on the next cycle
        step("call1", 1'b1, 8'h05, OP_CALL, 8'h10, 1'b0, 1'b1, 8'h15);
        chk("call1_depth", 32'(ras_depth), 1);
        step("ret1", 1'b1, 8'h15, OP_RET, 8'h00, 1'b0, 1'b1, 8'h06);
        chk("ret1_depth", 32'(ras_depth), 0);

        // Overflow: five CALLs into a four-deep stack
        for (int i = 1; i <= 5; i++) begin
            step($sformatf("ovcall%0d", i), 1'b1, 8'(i), OP_CALL, 8'h10, 1'b0, 1'b1, 8'(i + 16));
        end
        chk("ov_depth", 32'(ras_depth), 4);
        chk("ov_ovf", 32'(ras_ovf), 1);
        for (int k = 0; k < 4; k++) begin
            step($sformatf("ovret%0d", k), 1'b1, 8'h90, OP_RET, 8'h00, 1'b0, 1'b1, 8'(6 - k));
        end
        chk("drain_depth", 32'(ras_depth), 0);
        chk("drain_unf", 32'(ras_unf), 0);
        step("unfret", 1'b1, 8'h90, OP_RET, 8'h00, 1'b0, 1'b1, RST_VEC);
        chk("unf_flag", 32'(ras_unf), 1);
        chk("unf_depth", 32'(ras_depth), 0);

        // Asynchronous reset mid-cycle with two entries and a JMP in flight
        step("rcall0", 1'b1, 8'h30, OP_CALL, 8'h00, 1'b0, 1'b1, 8'h30);
        step("rcall1", 1'b1, 8'h31, OP_CALL, 8'h00, 1'b0, 1'b1, 8'h31);
        chk("mid_depth_pre", 32'(ras_depth), 2);
        @(negedge clk);
        instr_valid = 1'b1;
        pc          = 8'h50;
        op          = OP_JMP;
        offset      = 8'h02;
        e.j = 1'b1;
        e.a = 8'h52;
        sb.push_back(e);
        #1;
        sb_compare("mid_pre");
        #1;
        reset = 1'b0;
        e.j = 1'b0;
        e.a = 8'h00;
        sb.push_back(e);
        #1;
        sb_compare("mid_rst");
        chk("mid_depth_rst", 32'(ras_depth), 0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op          = OP_NONE;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_depth", 32'(ras_depth), 0);
        chk("rel_ovf", 32'(ras_ovf), 0);
        chk("rel_unf", 32'(ras_unf), 0);
        step("rel_ret", 1'b1, 8'h60, OP_RET, 8'h00, 1'b0, 1'b1, RST_VEC);

`ifdef REDIRECT_CNT_EN
        reset = 1'b0;
        #1;
        chk("cnt_rst", 32'(redirect_cnt), 0);
        @(negedge clk);
        reset = 1'b1;
        step("cnt0", 1'b1, 8'h20, OP_BEQ, 8'h04, 1'b1, 1'b1, 8'h24);
        step("cnt1", 1'b1, 8'h20, OP_BEQ, 8'h04, 1'b0, 1'b0, 8'h00);
        step("cnt2", 1'b1, 8'h20, OP_BNE, 8'h04, 1'b0, 1'b1, 8'h24);
        step("cnt3", 1'b1, 8'h20, OP_BNE, 8'h04, 1'b1, 1'b0, 8'h00);
        step("cnt4", 1'b1, 8'h20, OP_BEQ, 8'h04, 1'b1, 1'b1, 8'h24);
        chk("cnt_val", 32'(redirect_cnt), 3);
`endif

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jump_redirect_unit.md
Name: jump_redirect_unit

Overview:
- Producer side of the fetch-redirect interface: generates the jump flag and jump address that the fetch stage samples on posedge clk.
- Sits between decode/compare logic and the fetch stage.
- Resolves JMP, conditional branches, CALL and RET, and keeps a circular return-address stack (RAS) for CALL/RET.
- Redirect outputs are combinational from the current instruction so that single-cycle fetch is not stalled; RAS state is sequential.

Parameters:
- PC_W, 8, PC / address width; all address arithmetic is modulo 2^PC_W.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.
- RST_VEC, 0, redirect target used on RET with an empty RAS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  current instruction is valid; when 0, op is treated as NONE.
- pc  in  PC_W  PC of the instruction currently being executed.
- op  in  3  redirect opcode: NONE=0, JMP=1, BEQ=2, BNE=3, CALL=4, RET=5; values 6 and 7 are treated as NONE.
- offset  in  PC_W  signed two's-complement displacement for JMP, BEQ, BNE and CALL.
- cmp_eq  in  1  equality result from the ALU compare for the current instruction.
- jflag  out  1  take redirect this cycle; fetch loads new_jadd on the next posedge.
- new_jadd  out  PC_W  redirect target; driven to 0 whenever jflag=0.
- ras_depth  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_ovf  out  1  sticky flag: a push happened while the RAS was full.
- ras_unf  out  1  sticky flag: a pop happened while the RAS was empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - Stack pointer sp=0, ras_depth=0, ras_ovf=0, ras_unf=0, all RAS entries = 0.
  - jflag and new_jadd are forced to 0 combinationally for as long as reset=0.
  - A reset in the middle of a CALL/RET sequence discards the whole stack; there is no partial recovery.
- Target arithmetic: tgt = pc + offset, with offset sign-extended and the result truncated to PC_W bits (wraps past 255 and below 0). Return address ret = pc + 1 mod 2^PC_W.
- Decision, combinational, same cycle as the instruction:
  - NONE: jflag=0.
  - JMP: jflag=1, new_jadd=tgt.
  - BEQ: jflag=cmp_eq, new_jadd=tgt when taken.
  - BNE: jflag=~cmp_eq, new_jadd=tgt when taken.
  - CALL: jflag=1, new_jadd=tgt.
  - RET with ras_depth>0: jflag=1, new_jadd = entry[sp-1].
  - RET with ras_depth=0: jflag=1, new_jadd=RST_VEC.
- RAS update on posedge, only when instr_valid=1 and reset=1:
  - CALL: entry[sp] <= ret; sp <= sp+1 mod RAS_DEPTH; ras_depth <= min(ras_depth+1, RAS_DEPTH).
  - CALL when full: the oldest entry is overwritten (circular), ras_depth stays at RAS_DEPTH, ras_ovf <= 1.
  - RET with depth>0: sp <= sp-1 mod RAS_DEPTH; ras_depth <= ras_depth-1.
  - RET with depth=0: sp unchanged, ras_depth stays 0, ras_unf <= 1.
  - All other ops: no state change.
- Latency: redirect is 0 cycles (combinational). A RAS push is visible to a RET on the very next cycle.
- At most one op is handled per cycle, so a simultaneous push and pop is impossible by construction.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: REDIRECT_CNT_EN.
- When defined:
  - Adds output port redirect_cnt, 16 bits.
  - The counter increments on each posedge where jflag=1, saturates at 16'hFFFF, and is reset to 0.
- When undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - op encodings OP_NONE through OP_RET.
  - PC_W default.
  - Opcode width constant (3).
- Natural sub-module: ras_stack.
  - Circular storage, sp, depth and sticky flags.
  - push/pop inputs; top, depth, ovf and unf outputs.
- The top level holds the decision logic, target adder and optional counter.

Test Plan:
- JMP with pc=8'h10, offset=8'hFC: jflag=1, new_jadd=8'h0C. With offset=8'h05 and pc=8'hFE: new_jadd=8'h03 (wrap).
- BEQ with pc=8'h20, offset=8'h04: cmp_eq=1 gives jflag=1, new_jadd=8'h24. cmp_eq=0 gives jflag=0, new_jadd=0. BNE gives the inverse in both cases.
- CALL at pc=8'h05, offset=8'h10, then RET on the next cycle: first cycle new_jadd=8'h15 and ras_depth=1; RET gives new_jadd=8'h06 and ras_depth=0.
- Five CALLs from pc=1,2,3,4,5 with RAS_DEPTH=4: ras_ovf=1, ras_depth=4. Four RETs then return 6,5,4,3. A fifth RET gives new_jadd=RST_VEC and ras_unf=1.
- Assert reset low asynchronously mid-cycle with ras_depth=2 and op=JMP: jflag=0 immediately; after release, ras_depth=0 and both flags are 0.
- Build with REDIRECT_CNT_EN, run 3 taken and 2 not-taken branches: redirect_cnt=3. Build without the macro: the design compiles with no redirect_cnt port.
